// File: rtl/clint.sv
// -----------------------------------------------------------------------------
// clint -- core-local interruptor
//
// Word-addressed responder on the core data bus. It owns the machine software
// interrupt bit (msip), the 64-bit timer compare register (mtimecmp) and a
// free-running 64-bit timer (mtime). mtime advances once every clock_rate core
// cycles. The timer interrupt is raised while mtime >= mtimecmp.
//
// Register map (byte offset, clint_addr[15:0]; only [15:2] is decoded):
//   0x0000  msip            bit 0 R/W, bits 31:1 read 0
//   0x4000  mtimecmp[31:0]
//   0x4004  mtimecmp[63:32]
//   0xBFF8  mtime[31:0]
//   0xBFFC  mtime[63:32]
//   any other offset reads 0, ignores writes, and still responds.
//
// Parameters:
//   clock_rate   core cycles per mtime increment (>= 1)
//
// Ports:
//   clk           in   core clock, rising edge
//   rst           in   asynchronous reset, active low
//   clint_valid   in   request strobe, one cycle per access
//   clint_instr   in   fetch flag, ignored (treated as a data access)
//   clint_addr    in   byte address
//   clint_wdata   in   write data
//   clint_wstrb   in   byte enables, all-zero means read
//   clint_rdata   out  read data, non-zero only while clint_ready is high
//   clint_ready   out  response strobe, one cycle after clint_valid
//   clint_msip    out  machine software interrupt pending
//   clint_mtip    out  machine timer interrupt pending (registered compare)
//   clint_mtime   out  current mtime
// -----------------------------------------------------------------------------
module clint #(
   parameter int unsigned clock_rate = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clint_valid,
   input  logic        clint_instr,
   input  logic [31:0] clint_addr,
   input  logic [31:0] clint_wdata,
   input  logic [3:0]  clint_wstrb,
   output logic [31:0] clint_rdata,
   output logic        clint_ready,
   output logic        clint_msip,
   output logic        clint_mtip,
   output logic [63:0] clint_mtime
);

   // Prescaler counter needs at least one bit even when clock_rate is 1.
   localparam int unsigned CNT_W = (clock_rate > 1) ? $clog2(clock_rate) : 1;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(clock_rate - 1);

   // Word indices (byte offset >> 2) of the mapped registers.
   localparam logic [13:0] IDX_MSIP     = 14'h0000;
   localparam logic [13:0] IDX_MTCMP_LO = 14'h1000;
   localparam logic [13:0] IDX_MTCMP_HI = 14'h1001;
   localparam logic [13:0] IDX_MTIME_LO = 14'h2FFE;
   localparam logic [13:0] IDX_MTIME_HI = 14'h2FFF;

   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic             tick;
   logic [63:0]      mtime_q, mtime_d, mtime_inc;
   logic [63:0]      mtimecmp_q, mtimecmp_d;
   logic             msip_q, msip_d;
   logic             mtip_q, mtip_d;
   logic             ready_q, ready_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      rd_mux;
   logic [13:0]      word_idx;
   logic             wr_en;

   // Address bits outside [15:2] and the fetch flag carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{clint_instr, clint_addr[31:16], clint_addr[1:0]};

   // Replace the strobed bytes of old_val with the matching bytes of new_val.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_val[8*b +: 8];
         end
      end
      return res;
   endfunction

   assign word_idx = clint_addr[15:2];
   assign wr_en    = clint_valid && (clint_wstrb != 4'b0000);

   // Prescaler: free running, never touched by bus accesses.
   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
   end

   // The full 64-bit add lets the low-half carry reach the high half in the
   // same cycle.
   assign mtime_inc = mtime_q + {63'd0, tick};

   // Register writes. A write to an mtime half overlays only the strobed
   // bytes on the incremented value, so a coincident tick is never lost on
   // the bytes that were not written.
   always_comb begin
      mtime_d    = mtime_inc;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (wr_en) begin
         case (word_idx)
            IDX_MSIP: begin
               if (clint_wstrb[0]) begin
                  msip_d = clint_wdata[0];
               end
            end
            IDX_MTCMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  clint_wdata, clint_wstrb);
            IDX_MTCMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
            IDX_MTIME_LO: mtime_d[31:0]     = merge_bytes(mtime_inc[31:0],   clint_wdata, clint_wstrb);
            IDX_MTIME_HI: mtime_d[63:32]    = merge_bytes(mtime_inc[63:32],  clint_wdata, clint_wstrb);
            default: ;
         endcase
      end
   end

   // Read data comes from the current register values, before this cycle's
   // tick or write lands.
   always_comb begin
      rd_mux = 32'd0;
      case (word_idx)
         IDX_MSIP:     rd_mux = {31'd0, msip_q};
         IDX_MTCMP_LO: rd_mux = mtimecmp_q[31:0];
         IDX_MTCMP_HI: rd_mux = mtimecmp_q[63:32];
         IDX_MTIME_LO: rd_mux = mtime_q[31:0];
         IDX_MTIME_HI: rd_mux = mtime_q[63:32];
         default:      rd_mux = 32'd0;
      endcase
   end

   // Response path and registered compare. The compare uses register values,
   // which makes mtip trail an mtimecmp write by two cycles.
   always_comb begin
      ready_d = clint_valid;
      rdata_d = clint_valid ? rd_mux : 32'd0;
      mtip_d  = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_q  <= '0;
         mtime_q    <= 64'd0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip_q     <= 1'b0;
         mtip_q     <= 1'b0;
         ready_q    <= 1'b0;
         rdata_q    <= 32'd0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         mtip_q     <= mtip_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
      end
   end

   assign clint_rdata = rdata_q;
   assign clint_ready = ready_q;
   assign clint_msip  = msip_q;
   assign clint_mtip  = mtip_q;
   assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint.sv
// -----------------------------------------------------------------------------
// tb_clint -- bench for clint. Two instances (clock_rate 1 and 4) share one
// bus; a behavioural model of each runs alongside and is compared on every
// falling edge, on top of directed table and sequence checks.
// -----------------------------------------------------------------------------
module tb_clint;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic        instr = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  wstrb = 4'd0;

   logic [31:0] rdata1, rdata4;
   logic        ready1, ready4, msip1, msip4, mtip1, mtip4;
   logic [63:0] mtime1, mtime4;

   always #5 clk = ~clk;

   clint #(.clock_rate(1)) dut1 (
      .clk(clk), .rst(rst), .clint_valid(valid), .clint_instr(instr),
      .clint_addr(addr), .clint_wdata(wdata), .clint_wstrb(wstrb),
      .clint_rdata(rdata1), .clint_ready(ready1), .clint_msip(msip1),
      .clint_mtip(mtip1), .clint_mtime(mtime1)
   );

   clint #(.clock_rate(4)) dut4 (
      .clk(clk), .rst(rst), .clint_valid(valid), .clint_instr(instr),
      .clint_addr(addr), .clint_wdata(wdata), .clint_wstrb(wstrb),
      .clint_rdata(rdata4), .clint_ready(ready4), .clint_msip(msip4),
      .clint_mtip(mtip4), .clint_mtime(mtime4)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (index 0: rate 1, index 1: rate 4)
   logic        m_msip  [2];
   logic [63:0] m_mtime [2];
   logic [63:0] m_cmp   [2];
   logic        m_mtip  [2];
   logic        m_ready [2];
   logic [31:0] m_rdata [2];
   int unsigned m_cyc   [2];   // clock edges seen since reset release

   function automatic logic [31:0] bmask(input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
      return m;
   endfunction

   function automatic logic [31:0] m_read(input int k, input logic [15:0] off);
      case (off)
         16'h0000: return {31'd0, m_msip[k]};
         16'h4000: return m_cmp[k][31:0];
         16'h4004: return m_cmp[k][63:32];
         16'hBFF8: return m_mtime[k][31:0];
         16'hBFFC: return m_mtime[k][63:32];
         default:  return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_msip[k] = 1'b0; m_mtime[k] = 64'd0; m_cmp[k] = '1;
         m_mtip[k] = 1'b0; m_ready[k] = 1'b0; m_rdata[k] = 32'd0; m_cyc[k] = 0;
      end
   endtask

   task automatic m_step(input int k);
      int unsigned rate;
      logic        tk;
      logic [31:0] mk;
      logic [15:0] off;
      logic [63:0] nmt, ncmp;
      logic        nmsip;
      rate  = (k == 0) ? 1 : 4;
      tk    = (m_cyc[k] % rate) == rate - 1;
      mk    = bmask(wstrb);
      off   = {addr[15:2], 2'b00};
      nmt   = m_mtime[k] + (tk ? 64'd1 : 64'd0);
      ncmp  = m_cmp[k];
      nmsip = m_msip[k];
      if (valid && wstrb != 4'd0) begin
         case (off)
            16'h0000: if (wstrb[0]) nmsip = wdata[0];
            16'h4000: ncmp[31:0]  = (ncmp[31:0]  & ~mk) | (wdata & mk);
            16'h4004: ncmp[63:32] = (ncmp[63:32] & ~mk) | (wdata & mk);
            16'hBFF8: nmt[31:0]   = (nmt[31:0]   & ~mk) | (wdata & mk);
            16'hBFFC: nmt[63:32]  = (nmt[63:32]  & ~mk) | (wdata & mk);
            default: ;
         endcase
      end
      m_mtip[k]  = m_mtime[k] >= m_cmp[k];
      m_rdata[k] = valid ? m_read(k, off) : 32'd0;
      m_ready[k] = valid;
      m_mtime[k] = nmt;
      m_cmp[k]   = ncmp;
      m_msip[k]  = nmsip;
      m_cyc[k]++;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) m_reset();
      else for (int k = 0; k < 2; k++) m_step(k);
   end

   bit mon_en = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         chk("r1 mtime", mtime1, m_mtime[0]);
         chk("r1 mtip",  mtip1,  m_mtip[0]);
         chk("r1 msip",  msip1,  m_msip[0]);
         chk("r1 ready", ready1, m_ready[0]);
         chk("r1 rdata", rdata1, m_rdata[0]);
         chk("r4 mtime", mtime4, m_mtime[1]);
         chk("r4 mtip",  mtip4,  m_mtip[1]);
         chk("r4 msip",  msip4,  m_msip[1]);
         chk("r4 ready", ready4, m_ready[1]);
         chk("r4 rdata", rdata4, m_rdata[1]);
      end
   end

   // ---------------- directed vectors
   typedef struct {
      logic        vld;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_msip;
   } vec_t;

   vec_t tbl [16];

   task automatic bus(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      valid = v; addr = a; wdata = d; wstrb = s;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] v0;
      logic [31:0] alist [6];

      tbl[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 4'b0001, 1'b0, 32'h0,          1'b1};
      tbl[1]  = '{1'b1, 32'h0000_0000, 32'h0,         4'b0000, 1'b1, 32'h0000_0001, 1'b1};
      tbl[2]  = '{1'b1, 32'h0000_0002, 32'h0,         4'b0000, 1'b1, 32'h0000_0001, 1'b1};
      tbl[3]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0010, 1'b0, 32'h0,          1'b1};
      tbl[4]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFE, 4'b1111, 1'b0, 32'h0,          1'b0};
      tbl[5]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 4'b0000, 1'b1, 32'h0,          1'b0};
      tbl[6]  = '{1'b1, 32'h0000_4000, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0,          1'b0};
      tbl[7]  = '{1'b1, 32'h0000_4000, 32'h0,         4'b0000, 1'b1, 32'hFFBB_FFDD, 1'b0};
      tbl[8]  = '{1'b1, 32'h0000_4004, 32'h0,         4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b0};
      tbl[9]  = '{1'b1, 32'h0000_2000, 32'h1234_5678, 4'b1111, 1'b0, 32'h0,          1'b0};
      tbl[10] = '{1'b1, 32'h0000_2000, 32'h0,         4'b0000, 1'b1, 32'h0,          1'b0};
      tbl[11] = '{1'b1, 32'h0000_4000, 32'h0,         4'b0000, 1'b1, 32'hFFBB_FFDD, 1'b0};
      tbl[12] = '{1'b0, 32'h0000_4000, 32'h0,         4'b0000, 1'b1, 32'h0,          1'b0};
      tbl[13] = '{1'b1, 32'h0001_0000, 32'h0,         4'b0000, 1'b1, 32'h0,          1'b0};
      tbl[14] = '{1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0,          1'b0};
      tbl[15] = '{1'b1, 32'h0000_4000, 32'h0,         4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b0};

      alist[0] = 32'h0000; alist[1] = 32'h4000; alist[2] = 32'h4004;
      alist[3] = 32'hBFF8; alist[4] = 32'hBFFC; alist[5] = 32'h2000;

      m_reset();
      repeat (3) @(negedge clk);
      mon_en = 1'b1;

      // Reset release, idle 10 cycles
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle10 r1 mtime", mtime1, 64'd10);
      chk("idle10 r1 mtip",  mtip1,  1'b0);
      chk("idle10 r1 msip",  msip1,  1'b0);
      chk("idle10 r1 ready", ready1, 1'b0);
      chk("idle10 r4 mtime", mtime4, 64'd2);

      // Table of back-to-back accesses
      for (int i = 0; i < 16; i++) begin
         bus(tbl[i].vld, tbl[i].a, tbl[i].d, tbl[i].s);
         @(negedge clk);
         chk($sformatf("tbl[%0d] ready", i), ready1, tbl[i].vld);
         chk($sformatf("tbl[%0d] msip", i), msip1, tbl[i].exp_msip);
         if (tbl[i].chk_rd) chk($sformatf("tbl[%0d] rdata", i), rdata1, tbl[i].exp_rd);
      end
      bus(0, 0, 0, 0);
      @(negedge clk);

      // Timer match
      bus(1, 32'h4004, 32'd0, 4'hF); @(negedge clk);
      bus(1, 32'hBFF8, 32'd0, 4'hF); @(negedge clk);
      bus(1, 32'h4000, 32'd20, 4'hF); @(negedge clk);
      bus(0, 0, 0, 0);
      for (int t = 0; t < 100 && mtime1 != 64'd20; t++) @(negedge clk);
      chk("timer reach 20", mtime1, 64'd20);
      chk("timer mtip before", mtip1, 1'b0);
      @(negedge clk);
      chk("timer mtip rise", mtip1, 1'b1);
      bus(1, 32'h4000, 32'hFFFF_FFFF, 4'hF); @(negedge clk);
      bus(0, 0, 0, 0);
      chk("timer mtip hold", mtip1, 1'b1);
      @(negedge clk);
      chk("timer mtip drop", mtip1, 1'b0);

      // Carry across halves and 64-bit wrap
      bus(1, 32'hBFF8, 32'hFFFF_FFFE, 4'hF); @(negedge clk);
      bus(1, 32'hBFFC, 32'h0000_0001, 4'hF); @(negedge clk);
      bus(0, 0, 0, 0);
      chk("carry step1", mtime1, 64'h0000_0001_FFFF_FFFF);
      @(negedge clk);
      chk("carry step2", mtime1, 64'h0000_0002_0000_0000);
      bus(1, 32'hBFFC, 32'hFFFF_FFFF, 4'hF); @(negedge clk);
      bus(1, 32'hBFF8, 32'hFFFF_FFFF, 4'hF); @(negedge clk);
      bus(0, 0, 0, 0);
      chk("wrap all ones", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      chk("wrap to zero", mtime1, 64'd0);

      // Prescaler, clock_rate 4
      v0 = mtime4;
      for (int t = 0; t < 8 && mtime4 == v0; t++) @(negedge clk);
      chk("r4 tick seen", mtime4 != v0, 1'b1);
      for (int rep = 0; rep < 2; rep++) begin
         v0 = mtime4;
         repeat (3) begin
            @(negedge clk);
            chk("r4 hold", mtime4, v0);
         end
         @(negedge clk);
         chk("r4 step", mtime4, v0 + 64'd1);
      end
      // The next tick lands on the fourth edge from here; write on it.
      repeat (3) @(negedge clk);
      bus(1, 32'hBFF8, 32'h0000_0100, 4'hF); @(negedge clk);
      bus(0, 0, 0, 0);
      chk("r4 write wins", mtime4[31:0], 32'h0000_0100);
      chk("r1 write low",  mtime1[31:0], 32'h0000_0100);
      repeat (3) begin
         @(negedge clk);
         chk("r4 after write hold", mtime4[31:0], 32'h0000_0100);
      end
      @(negedge clk);
      chk("r4 after write step", mtime4[31:0], 32'h0000_0101);

      // Asynchronous reset in the middle of an access
      bus(1, 32'h0000, 32'd1, 4'b0001); @(negedge clk);
      bus(1, 32'h0000, 32'd0, 4'b0000);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst r1 ready", ready1, 1'b0);
      chk("arst r1 rdata", rdata1, 32'd0);
      chk("arst r1 msip",  msip1,  1'b0);
      chk("arst r1 mtime", mtime1, 64'd0);
      chk("arst r1 mtip",  mtip1,  1'b0);
      chk("arst r4 ready", ready4, 1'b0);
      repeat (2) @(negedge clk);
      bus(0, 0, 0, 0);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post arst ready", ready1, 1'b0);
      end
      bus(1, 32'h4004, 32'd0, 4'b0000); @(negedge clk);
      bus(0, 0, 0, 0);
      chk("post arst rd ready", ready1, 1'b1);
      chk("post arst rd cmp",   rdata1, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("post arst ready low", ready1, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = alist[$urandom_range(0, 5)] | ($urandom & 32'hFFFF_0003);
         instr = 1'($urandom_range(0, 1));
         bus(($urandom_range(0, 3) != 0), a, $urandom,
             ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'd0);
         @(negedge clk);
      end
      bus(0, 0, 0, 0);
      instr = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
